dlx_mem_arbiter: RTL and testbench
==================================

DLX_MEM_ARBITER -- requirements
Module: dlx_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch request waits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles a memory access may wait for m_ack.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_req  input  1  fetch request; held high until i_data_valid.
REQ-006 SHALL have port i_address  input  32  fetch address.
REQ-007 SHALL have port i_data_read  output  32  fetched instruction word.
REQ-008 SHALL have port i_data_valid  output  1  one-cycle pulse: fetch complete.
REQ-009 SHALL have port d_req  input  1  data access request; held high until d_data_valid.
REQ-010 SHALL have port d_write_enable  input  1  data access is a write (1) or a read (0).
REQ-011 SHALL have port d_address  input  32  data address.
REQ-012 SHALL have port d_data_write  input  32  store data.
REQ-013 SHALL have port d_data_read  output  32  load data.
REQ-014 SHALL have port d_data_valid  output  1  one-cycle pulse: data access complete, read or write.
REQ-015 SHALL have port m_req  output  1  shared single-port memory request.
REQ-016 SHALL have port m_we  output  1  memory write strobe.
REQ-017 SHALL have port m_address  output  32  memory address.
REQ-018 SHALL have port m_wdata  output  32  memory write data.
REQ-019 SHALL have port m_rdata  input  32  memory read data; valid when m_ack is high.
REQ-020 SHALL have port m_ack  input  1  memory completion; one cycle; latency of 1 or more cycles.
REQ-021 SHALL have port bus_error  output  1  sticky flag: an access timed out.

Function
REQ-022 SHALL implement FSM states IDLE, I_ACC and D_ACC.
REQ-023 In IDLE, with requests present, the block SHALL grant data over fetch, except per REQ-024.
REQ-024 SHALL grant fetch when i_req is high and starve_cnt == STARVE_LIMIT.
- starve_cnt increments on each data grant while i_req is high.
- starve_cnt clears on any fetch grant.
REQ-025 On a grant, the block SHALL register m_address, m_we and m_wdata from the granted port and assert m_req.
- Assertion occurs at the same edge as the transition out of IDLE.
- m_we and m_wdata are 0 for a fetch.
REQ-026 m_req, m_address, m_we and m_wdata SHALL stay stable until the cycle m_ack is sampled high.
REQ-027 On m_ack in I_ACC or D_ACC, the block SHALL:
- register m_rdata into i_data_read or d_data_read (read only; d_data_read holds for a write);
- pulse the matching valid for exactly one cycle, starting the next cycle;
- drop m_req;
- return to IDLE.
REQ-028 After each completion, m_req SHALL be low for at least one cycle; the earliest new grant is in the valid-pulse cycle.
REQ-029 A requester whose valid is pulsing this cycle SHALL NOT be re-granted this cycle.
REQ-030 i_data_read and d_data_read SHALL hold their last value until the next completion on that port.
REQ-031 SHALL count cycles in I_ACC and D_ACC with an 8-bit-or-wider timeout counter.
- At TIMEOUT_CYCLES without m_ack: set bus_error, drop m_req, pulse the matching valid with data 0, return to IDLE.
REQ-032 m_ack arriving in IDLE SHALL be ignored.
REQ-033 Request deassertion mid-access SHALL NOT abort the memory access; its completion is still signalled.
REQ-034 Simultaneous i_req and d_req on the first cycle after reset SHALL grant data.

Reset
REQ-035 On reset the block SHALL:
- enter IDLE;
- clear m_req, m_we, m_address, m_wdata, i_data_read, d_data_read, both valids, bus_error, starve_cnt and the timeout counter to 0;
- abandon any access in flight with no valid pulse.

Verification
REQ-036 Lone fetch: i_req=1, i_address=0x40, m_ack after 2 cycles with m_rdata=0xDEADBEEF.
- m_req high for 2 cycles; i_data_valid pulses once; i_data_read=0xDEADBEEF.
REQ-037 Store: d_req=1, d_write_enable=1, d_address=0x100, d_data_write=0x55.
- m_we=1, m_wdata=0x55 until m_ack; d_data_valid pulses once; d_data_read unchanged.
REQ-038 Contention: i_req and d_req both held high continuously, m_ack latency 1.
- Grant order: D,D,D,D,I,D,D,D,D,I.
- m_req low at least one cycle between grants.
REQ-039 Timeout: d_req=1, m_ack never asserted.
- After 255 cycles: bus_error=1, d_data_valid pulses with d_data_read=0, FSM returns to IDLE.
- bus_error stays high until reset.
REQ-040 Reset mid-access: reset_n=0 while in D_ACC.
- Next edge: m_req=0, bus_error=0, no valid pulse.
- A stale m_ack after reset is ignored.

Source files
------------

// File: rtl/dlx_mem_arbiter.sv
// dlx_mem_arbiter: shares one single-port memory between the DLX fetch and
// data ports. Data wins by default; a starvation counter forces a fetch grant
// after STARVE_LIMIT data grants in a row, and a timeout counter aborts
// accesses the memory never acknowledges (setting the sticky bus_error).
module dlx_mem_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    // fetch port
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic [31:0] i_data_read,
    output logic        i_data_valid,
    // data port
    input  logic        d_req,
    input  logic        d_write_enable,
    input  logic [31:0] d_address,
    input  logic [31:0] d_data_write,
    output logic [31:0] d_data_read,
    output logic        d_data_valid,
    // shared memory
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_address,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        bus_error
);

    localparam int SW_RAW = $clog2(STARVE_LIMIT + 1);
    localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : TW_RAW;

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

    state_t          r_state,        w_state_next;
    logic            r_m_req,        w_m_req;
    logic            r_m_we,         w_m_we;
    logic [31:0]     r_m_address,    w_m_address;
    logic [31:0]     r_m_wdata,      w_m_wdata;
    logic [31:0]     r_i_data_read,  w_i_data_read;
    logic [31:0]     r_d_data_read,  w_d_data_read;
    logic            r_i_data_valid, w_i_data_valid;
    logic            r_d_data_valid, w_d_data_valid;
    logic            r_bus_error,    w_bus_error;
    logic [SW-1:0]   r_starve_cnt,   w_starve_cnt;
    logic [TW-1:0]   r_tmo_cnt,      w_tmo_cnt;

    logic            w_starved;
    logic            w_timeout;
    logic            w_grant_i;
    logic            w_grant_d;

    // Fetch is forced once the data port has won STARVE_LIMIT times in a row.
    assign w_starved = (r_starve_cnt == SW'(STARVE_LIMIT));
    // Final cycle of the wait budget with still no acknowledge.
    assign w_timeout = !m_ack && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // A port whose valid is pulsing is not re-granted this cycle. While d_req
    // is present and fetch is not starved, the arbiter waits for the data
    // port rather than slipping a fetch into the data port's pulse cycle.
    assign w_grant_i = (r_state == IDLE) && i_req && !r_i_data_valid
                       && (w_starved || !d_req);
    assign w_grant_d = (r_state == IDLE) && !w_grant_i && d_req && !r_d_data_valid;

    // Next-state and next-register values for the whole block.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        w_state_next   = r_state;
        w_m_req        = r_m_req;
        w_m_we         = r_m_we;
        w_m_address    = r_m_address;
        w_m_wdata      = r_m_wdata;
        w_i_data_read  = r_i_data_read;
        w_d_data_read  = r_d_data_read;
        w_i_data_valid = 1'b0;
        w_d_data_valid = 1'b0;
        w_bus_error    = r_bus_error;
        w_starve_cnt   = r_starve_cnt;
        w_tmo_cnt      = r_tmo_cnt;

        case (r_state)
            IDLE: begin
                if (w_grant_i) begin
                    w_state_next = I_ACC;
                    w_m_req      = 1'b1;
                    w_m_we       = 1'b0;
                    w_m_address  = i_address;
                    w_m_wdata    = '0;
                    w_starve_cnt = '0;
                    w_tmo_cnt    = '0;
                end else if (w_grant_d) begin
                    w_state_next = D_ACC;
                    w_m_req      = 1'b1;
                    w_m_we       = d_write_enable;
                    w_m_address  = d_address;
                    w_m_wdata    = d_data_write;
                    w_tmo_cnt    = '0;
                    if (i_req && !w_starved) begin
                        w_starve_cnt = r_starve_cnt + 1'b1;
                    end
                end
            end
            I_ACC: begin
                if (m_ack) begin
                    w_i_data_read  = m_rdata;
                    w_i_data_valid = 1'b1;
                    w_m_req        = 1'b0;
                    w_state_next   = IDLE;
                end else if (w_timeout) begin
                    w_i_data_read  = '0;
                    w_i_data_valid = 1'b1;
                    w_bus_error    = 1'b1;
                    w_m_req        = 1'b0;
                    w_state_next   = IDLE;
                end else begin
                    w_tmo_cnt = r_tmo_cnt + 1'b1;
                end
            end
            D_ACC: begin
                if (m_ack) begin
                    // A store completes without touching the load register.
                    if (!r_m_we) begin
                        w_d_data_read = m_rdata;
                    end
                    w_d_data_valid = 1'b1;
                    w_m_req        = 1'b0;
                    w_state_next   = IDLE;
                end else if (w_timeout) begin
                    w_d_data_read  = '0;
                    w_d_data_valid = 1'b1;
                    w_bus_error    = 1'b1;
                    w_m_req        = 1'b0;
                    w_state_next   = IDLE;
                end else begin
                    w_tmo_cnt = r_tmo_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_m_req      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before this edge.
        if (!reset_n) begin
            r_state        <= IDLE;
            r_m_req        <= 1'b0;
            r_m_we         <= 1'b0;
            r_m_address    <= '0;
            r_m_wdata      <= '0;
            r_i_data_read  <= '0;
            r_d_data_read  <= '0;
            r_i_data_valid <= 1'b0;
            r_d_data_valid <= 1'b0;
            r_bus_error    <= 1'b0;
            r_starve_cnt   <= '0;
            r_tmo_cnt      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_m_req        <= w_m_req;
            r_m_we         <= w_m_we;
            r_m_address    <= w_m_address;
            r_m_wdata      <= w_m_wdata;
            r_i_data_read  <= w_i_data_read;
            r_d_data_read  <= w_d_data_read;
            r_i_data_valid <= w_i_data_valid;
            r_d_data_valid <= w_d_data_valid;
            r_bus_error    <= w_bus_error;
            r_starve_cnt   <= w_starve_cnt;
            r_tmo_cnt      <= w_tmo_cnt;
        end
    end

    assign m_req        = r_m_req;
    assign m_we         = r_m_we;
    assign m_address    = r_m_address;
    assign m_wdata      = r_m_wdata;
    assign i_data_read  = r_i_data_read;
    assign d_data_read  = r_d_data_read;
    assign i_data_valid = r_i_data_valid;
    assign d_data_valid = r_d_data_valid;
    assign bus_error    = r_bus_error;

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// tb_dlx_mem_arbiter: directed vector table for single accesses, followed by
// hand-written sequences for contention, timeout and reset mid-access.
module tb_dlx_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_address = '0;
    logic [31:0] i_data_read;
    logic        i_data_valid;
    logic        d_req = 1'b0;
    logic        d_write_enable = 1'b0;
    logic [31:0] d_address = '0;
    logic [31:0] d_data_write = '0;
    logic [31:0] d_data_read;
    logic        d_data_valid;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_address;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic        bus_error;

    int n_checks = 0;
    int n_errors = 0;

    dlx_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_address(i_address),
        .i_data_read(i_data_read), .i_data_valid(i_data_valid),
        .d_req(d_req), .d_write_enable(d_write_enable),
        .d_address(d_address), .d_data_write(d_data_write),
        .d_data_read(d_data_read), .d_data_valid(d_data_valid),
        .m_req(m_req), .m_we(m_we), .m_address(m_address),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; i_address = '0;
        d_req = 1'b0; d_write_enable = 1'b0; d_address = '0; d_data_write = '0;
        m_ack = 1'b0; m_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        m_ack;
        logic [31:0] m_rdata;
        logic        e_m_req;
        logic        e_m_we;
        logic [31:0] e_m_addr;
        logic [31:0] e_m_wdata;
        logic        e_i_valid;
        logic [31:0] e_i_rdata;
        logic        e_d_valid;
        logic [31:0] e_d_rdata;
    } vec_t;

    vec_t vecs[12];
    int   exp_grant[10];
    int   got_grant[10];

    initial begin
        int n_g;
        int overlap;
        int hi;
        int early_err;
        logic prev_req;

        // inputs: i_req i_addr d_req d_we d_addr d_wdata m_ack m_rdata
        // expect: m_req m_we m_addr m_wdata i_valid i_rdata d_valid d_rdata
        // Lone fetch, ack in the second request cycle.
        vecs[0]  = '{1, 32'h40, 0, 0, 0, 0, 0, 0,           1, 0, 32'h40, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 32'h40, 0, 0, 0, 0, 0, 0,           1, 0, 32'h40, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 32'h40, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0};
        // Pulse cycle: fetch still requesting, not re-granted; stray ack ignored.
        vecs[3]  = '{1, 32'h40, 0, 0, 0, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        // Store: write strobe and data held, load register untouched.
        vecs[5]  = '{0, 0, 1, 1, 32'h100, 32'h55, 0, 0,     1, 1, 32'h100, 32'h55, 0, 32'hDEADBEEF, 0, 0};
        vecs[6]  = '{0, 0, 1, 1, 32'h100, 32'h55, 0, 0,     1, 1, 32'h100, 32'h55, 0, 32'hDEADBEEF, 0, 0};
        vecs[7]  = '{0, 0, 1, 1, 32'h100, 32'h55, 1, 32'hAAAA5555, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        // Load; requester drops d_req mid-access, completion still signalled.
        vecs[9]  = '{0, 0, 1, 0, 32'h200, 32'h77, 0, 0,     1, 0, 32'h200, 32'h77, 0, 32'hDEADBEEF, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 32'h200, 32'h77, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 32'hCAFEF00D};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 32'hCAFEF00D};

        exp_grant = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};  // 0 = data, 1 = fetch

        // ---------------- reset state ----------------
        do_reset();
        check("reset m_req", {31'b0, m_req}, 0);
        check("reset m_we", {31'b0, m_we}, 0);
        check("reset m_address", m_address, 0);
        check("reset m_wdata", m_wdata, 0);
        check("reset i_data_read", i_data_read, 0);
        check("reset d_data_read", d_data_read, 0);
        check("reset i_data_valid", {31'b0, i_data_valid}, 0);
        check("reset d_data_valid", {31'b0, d_data_valid}, 0);
        check("reset bus_error", {31'b0, bus_error}, 0);

        // ---------------- vector table ----------------
        for (int v = 0; v < 12; v++) begin
            i_req = vecs[v].i_req;          i_address = vecs[v].i_addr;
            d_req = vecs[v].d_req;          d_write_enable = vecs[v].d_we;
            d_address = vecs[v].d_addr;     d_data_write = vecs[v].d_wdata;
            m_ack = vecs[v].m_ack;          m_rdata = vecs[v].m_rdata;
            step();
            check($sformatf("vec%0d m_req", v), {31'b0, m_req}, {31'b0, vecs[v].e_m_req});
            if (vecs[v].e_m_req) begin
                check($sformatf("vec%0d m_we", v), {31'b0, m_we}, {31'b0, vecs[v].e_m_we});
                check($sformatf("vec%0d m_address", v), m_address, vecs[v].e_m_addr);
                check($sformatf("vec%0d m_wdata", v), m_wdata, vecs[v].e_m_wdata);
            end
            check($sformatf("vec%0d i_data_valid", v), {31'b0, i_data_valid}, {31'b0, vecs[v].e_i_valid});
            check($sformatf("vec%0d i_data_read", v), i_data_read, vecs[v].e_i_rdata);
            check($sformatf("vec%0d d_data_valid", v), {31'b0, d_data_valid}, {31'b0, vecs[v].e_d_valid});
            check($sformatf("vec%0d d_data_read", v), d_data_read, vecs[v].e_d_rdata);
            check($sformatf("vec%0d bus_error", v), {31'b0, bus_error}, 0);
        end

        // ---------------- contention, ack latency 1 ----------------
        do_reset();
        i_req = 1'b1; i_address = 32'h1000;
        d_req = 1'b1; d_address = 32'h2000;
        n_g = 0; overlap = 0; prev_req = 1'b0;
        for (int c = 0; c < 300 && n_g < 10; c++) begin
            step();
            if (m_req && !prev_req) begin
                got_grant[n_g] = (m_address == 32'h1000) ? 1 : 0;
                n_g++;
            end
            if (m_req && (i_data_valid || d_data_valid)) overlap++;
            prev_req = m_req;
            m_ack = m_req;
            m_rdata = 32'h0000_0A00 + 32'(n_g);
        end
        check("contention grant count", 32'(n_g), 10);
        for (int k = 0; k < 10; k++) begin
            if (k < n_g) check($sformatf("contention grant %0d", k), 32'(got_grant[k]), 32'(exp_grant[k]));
        end
        check("contention m_req low at completion", 32'(overlap), 0);

        // ---------------- timeout ----------------
        do_reset();
        d_req = 1'b1; d_address = 32'h300;
        step();
        m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
        step();
        check("tmo pre-load d_data_read", d_data_read, 32'hCAFEF00D);
        m_ack = 1'b0; d_req = 1'b0;
        step();
        d_req = 1'b1; d_address = 32'h304;
        step();
        hi = 0; early_err = 0;
        for (int c = 0; c < 400 && m_req; c++) begin
            hi++;
            if (bus_error) early_err++;
            step();
        end
        check("tmo m_req high cycles", 32'(hi), 255);
        check("tmo bus_error early", 32'(early_err), 0);
        check("tmo bus_error", {31'b0, bus_error}, 1);
        check("tmo d_data_valid", {31'b0, d_data_valid}, 1);
        check("tmo d_data_read", d_data_read, 0);
        d_req = 1'b0;
        step();
        check("tmo valid single cycle", {31'b0, d_data_valid}, 0);
        check("tmo bus_error sticky", {31'b0, bus_error}, 1);
        i_req = 1'b1; i_address = 32'h40;
        step();
        m_ack = 1'b1; m_rdata = 32'h0000_1234;
        step();
        check("tmo later fetch valid", {31'b0, i_data_valid}, 1);
        check("tmo later fetch data", i_data_read, 32'h0000_1234);
        check("tmo bus_error still sticky", {31'b0, bus_error}, 1);
        i_req = 1'b0; m_ack = 1'b0;
        step();

        // ---------------- reset mid-access ----------------
        d_req = 1'b1; d_write_enable = 1'b1; d_address = 32'h500; d_data_write = 32'h99;
        step();
        check("rst grant m_req", {31'b0, m_req}, 1);
        step();
        check("rst in D_ACC m_req", {31'b0, m_req}, 1);
        reset_n = 1'b0;
        step();
        check("rst m_req", {31'b0, m_req}, 0);
        check("rst m_we", {31'b0, m_we}, 0);
        check("rst m_address", m_address, 0);
        check("rst bus_error", {31'b0, bus_error}, 0);
        check("rst d_data_valid", {31'b0, d_data_valid}, 0);
        reset_n = 1'b1;
        d_req = 1'b0; d_write_enable = 1'b0;
        m_ack = 1'b1; m_rdata = 32'h0000_0BAD;
        step();
        check("stale ack m_req", {31'b0, m_req}, 0);
        check("stale ack d_data_valid", {31'b0, d_data_valid}, 0);
        check("stale ack i_data_valid", {31'b0, i_data_valid}, 0);
        m_ack = 1'b0;
        step();
        check("stale ack d_data_valid later", {31'b0, d_data_valid}, 0);
        check("stale ack d_data_read", d_data_read, 0);
        check("stale ack i_data_read", i_data_read, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
